// File: rtl/snoop_arb_pkg.sv
// ---------------------------------------------------------------------------
// snoop_arb_pkg
// Shared definitions for the snoop arbiter blocks.
//   state_e         : grant controller state encoding
//   TAG_SZ_DEFAULT  : default width of an agent tag
//   clog2()         : ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package snoop_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STAGED = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DROP   = 2'd3
    } state_e;

    localparam int TAG_SZ_DEFAULT = 5;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : snoop_arb_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   inc : increment request this cycle
//   cnt : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/snoop_grant_ctrl.sv
// ---------------------------------------------------------------------------
// snoop_grant_ctrl
// Pre-fetches one winning tag from the tag-tree root, routes the next snooped
// packet to that agent and pulses done when its last beat is written.
// Packets arriving with no tag staged are discarded and counted.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   tree_tag     : winning agent tag at the tree root
//   tree_rdy     : tree root has a ready agent
//   tree_ack     : claim of the current root tag (combinational)
//   snoop_valid  : snooper beat valid
//   snoop_sof    : first beat of a packet (qualified by snoop_valid)
//   snoop_last   : last beat of a packet (qualified by snoop_valid)
//   grant_tag    : agent the snooper writes to (0 when grant_vld is low)
//   grant_vld    : grant_tag is meaningful
//   done         : one-cycle pulse, packet completed into done_tag
//   done_tag     : agent that received the completed packet
//   dropping     : current packet is being discarded
//   pkt_cnt      : delivered packets, saturating
//   drop_cnt     : discarded packets, saturating
// ---------------------------------------------------------------------------
module snoop_grant_ctrl
    import snoop_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int TAG_SZ      = TAG_SZ_DEFAULT,
    parameter int ACK_HOLDOFF = 1,
    parameter int CNT_SZ      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_SZ-1:0] tree_tag,
    input  logic              tree_rdy,
    output logic              tree_ack,
    input  logic              snoop_valid,
    input  logic              snoop_sof,
    input  logic              snoop_last,
    output logic [TAG_SZ-1:0] grant_tag,
    output logic              grant_vld,
    output logic              done,
    output logic [TAG_SZ-1:0] done_tag,
    output logic              dropping,
    output logic [CNT_SZ-1:0] pkt_cnt,
    output logic [CNT_SZ-1:0] drop_cnt
);

    localparam int HOLD_W = (ACK_HOLDOFF > 0) ? clog2(ACK_HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ACK_HOLDOFF);

    // Every agent index must be representable as a tag.
    if ((1 << TAG_SZ) < N) begin : g_bad_tag_sz
        $error("snoop_grant_ctrl: TAG_SZ too small for N agents");
    end

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TAG_SZ-1:0]   staged_tag_q, staged_tag_d;
    logic                drop_ret_q, drop_ret_d;   // DROP returns to STAGED
    logic                done_q, done_d;
    logic [TAG_SZ-1:0]   done_tag_q, done_tag_d;
    logic                pkt_inc;
    logic                drop_inc;
    logic                sof_v;
    logic                last_v;

    assign sof_v  = snoop_valid && snoop_sof;
    assign last_v = snoop_valid && snoop_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            drop_ret_q <= 1'b0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            drop_ret_q <= drop_ret_d;
            done_q     <= done_d;
            done_tag_q <= done_tag_d;
        end
    end

    // The staged tag is only observed while grant_vld is high, so it needs
    // no reset.
    always_ff @(posedge clk) begin
        staged_tag_q <= staged_tag_d;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        staged_tag_d = staged_tag_q;
        drop_ret_d   = drop_ret_q;
        done_d       = 1'b0;
        done_tag_d   = done_tag_q;
        pkt_inc      = 1'b0;
        drop_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
                if (tree_ack) begin
                    // The ack wins a collision with sof: the tag is kept for
                    // the next packet while this one is discarded.
                    staged_tag_d = tree_tag;
                    state_d      = ST_STAGED;
                    if (sof_v) begin
                        if (last_v) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_d    = ST_DROP;
                            drop_ret_d = 1'b1;
                        end
                    end
                end else if (sof_v) begin
                    if (last_v) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d    = ST_DROP;
                        drop_ret_d = 1'b0;
                    end
                end
            end

            ST_STAGED: begin
                if (sof_v) begin
                    if (last_v) begin
                        done_d     = 1'b1;
                        done_tag_d = staged_tag_q;
                        pkt_inc    = 1'b1;
                        state_d    = ST_IDLE;
                        hold_d     = HOLD_LOAD;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                // A stray sof mid-packet is ignored; only last ends it.
                if (last_v) begin
                    done_d     = 1'b1;
                    done_tag_d = staged_tag_q;
                    pkt_inc    = 1'b1;
                    state_d    = ST_IDLE;
                    hold_d     = HOLD_LOAD;
                end
            end

            ST_DROP: begin
                if (last_v) begin
                    drop_inc = 1'b1;
                    if (drop_ret_q) begin
                        state_d = ST_STAGED;
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        tree_ack  = !rst && (state_q == ST_IDLE) && (hold_q == '0) && tree_rdy;
        grant_vld = (state_q == ST_STAGED) || (state_q == ST_BUSY);
        grant_tag = grant_vld ? staged_tag_q : '0;
        dropping  = (state_q == ST_DROP);
        done      = done_q;
        done_tag  = done_tag_q;
    end

    sat_counter #(.W(CNT_SZ)) u_pkt_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pkt_inc),
        .cnt (pkt_cnt)
    );

    sat_counter #(.W(CNT_SZ)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

endmodule : snoop_grant_ctrl

// File: tb/tb_snoop_grant_ctrl.sv
module tb_snoop_grant_ctrl;

    localparam int N           = 4;
    localparam int TAG_SZ      = 5;
    localparam int ACK_HOLDOFF = 2;
    localparam int CNT_SZ      = 2;
    localparam int MAXC        = (1 << CNT_SZ) - 1;

    logic              clk;
    logic              rst;
    logic [TAG_SZ-1:0] tree_tag;
    logic              tree_rdy;
    logic              tree_ack;
    logic              snoop_valid;
    logic              snoop_sof;
    logic              snoop_last;
    logic [TAG_SZ-1:0] grant_tag;
    logic              grant_vld;
    logic              done;
    logic [TAG_SZ-1:0] done_tag;
    logic              dropping;
    logic [CNT_SZ-1:0] pkt_cnt;
    logic [CNT_SZ-1:0] drop_cnt;

    int vectors;
    int miscompares;
    logic ack_seen;

    // Reference model: tag ownership, packet disposition and cooldown.
    bit m_has_tag;
    int m_tag;
    int m_mode;      // 0 no packet, 1 delivering, 2 discarding
    int m_cool;
    bit m_done;
    int m_done_tag;
    int m_pkt;
    int m_drop;

    snoop_grant_ctrl #(
        .N(N), .TAG_SZ(TAG_SZ), .ACK_HOLDOFF(ACK_HOLDOFF), .CNT_SZ(CNT_SZ)
    ) dut (
        .clk(clk), .rst(rst),
        .tree_tag(tree_tag), .tree_rdy(tree_rdy), .tree_ack(tree_ack),
        .snoop_valid(snoop_valid), .snoop_sof(snoop_sof), .snoop_last(snoop_last),
        .grant_tag(grant_tag), .grant_vld(grant_vld),
        .done(done), .done_tag(done_tag), .dropping(dropping),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_has_tag  = 0;
        m_tag      = 0;
        m_mode     = 0;
        m_cool     = 0;
        m_done     = 0;
        m_done_tag = 0;
        m_pkt      = 0;
        m_drop     = 0;
    endtask

    function automatic bit exp_ack();
        return !rst && !m_has_tag && (m_mode == 0) && (m_cool == 0) && tree_rdy;
    endfunction

    task automatic model_finish();
        m_done     = 1;
        m_done_tag = m_tag;
        if (m_pkt < MAXC) m_pkt++;
        m_has_tag  = 0;
        m_mode     = 0;
        m_cool     = ACK_HOLDOFF;
    endtask

    task automatic model_step();
        bit ack;
        bit sofv;
        bit lastv;
        ack   = exp_ack();
        sofv  = snoop_valid && snoop_sof;
        lastv = snoop_valid && snoop_last;
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (!m_has_tag && m_mode == 0) begin
            if (ack) begin
                m_has_tag = 1;
                m_tag     = int'(tree_tag);
            end
            if (sofv) begin
                if (lastv) begin
                    if (m_drop < MAXC) m_drop++;
                end else begin
                    m_mode = 2;
                end
            end
            if (!m_has_tag && m_mode == 0 && m_cool > 0) m_cool--;
        end else if (m_mode == 2) begin
            if (lastv) begin
                if (m_drop < MAXC) m_drop++;
                m_mode = 0;
                if (!m_has_tag) m_cool = ACK_HOLDOFF;
            end
        end else if (m_mode == 0) begin
            if (sofv) begin
                if (lastv) model_finish();
                else m_mode = 1;
            end
        end else begin
            if (lastv) model_finish();
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        bit gv;
        @(negedge clk);
        gv = m_has_tag && (m_mode != 2);
        ack_seen = tree_ack;
        chk("tree_ack",  32'(tree_ack),  32'(exp_ack()));
        chk("grant_vld", 32'(grant_vld), 32'(gv));
        chk("grant_tag", 32'(grant_tag), gv ? 32'(m_tag) : 32'd0);
        chk("dropping",  32'(dropping),  32'(m_mode == 2));
        chk("done",      32'(done),      32'(m_done));
        chk("done_tag",  32'(done_tag),  32'(m_done_tag));
        chk("pkt_cnt",   32'(pkt_cnt),   32'(m_pkt));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic rdy, input int tag, input logic v,
                         input logic s, input logic l);
        tree_rdy    = rdy;
        tree_tag    = TAG_SZ'(tag);
        snoop_valid = v;
        snoop_sof   = s;
        snoop_last  = l;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (n) cycle();
    endtask

    // Packet of 'beats' beats, back-to-back.
    task automatic packet(input int beats);
        for (int b = 0; b < beats; b++) begin
            drive(1'b0, 0, 1'b1, b == 0, b == beats - 1);
            cycle();
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Wait out any holdoff, fetch a tag, deliver a packet.
    task automatic deliver(input int tag, input int beats);
        idle(ACK_HOLDOFF + 1);
        drive(1'b1, tag, 1'b0, 1'b0, 1'b0);
        cycle();
        packet(beats);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ack_seen    = 1'b0;
        model_reset();

        // Reset; tree_rdy high to show the ack is masked during reset.
        rst = 1'b1;
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(tree_ack), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_tag", 32'(grant_tag), 32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_done_tag",  32'(done_tag),  32'd0);
        chk("rst_pkt_cnt",   32'(pkt_cnt),   32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);

        // Single fetch, then a 4-beat packet.
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("fetch_ack", 32'(ack_seen), 32'd1);
        chk("fetch_gvld", 32'(grant_vld), 32'd1);
        chk("fetch_gtag", 32'(grant_tag), 32'd3);
        cycle();
        chk("fetch_ack_once", 32'(ack_seen), 32'd0);
        packet(4);
        chk("pkt4_done", 32'(done), 32'd1);
        chk("pkt4_done_tag", 32'(done_tag), 32'd3);
        chk("pkt4_pkt_cnt", 32'(pkt_cnt), 32'd1);
        idle(1);
        chk("pkt4_done_pulse", 32'(done), 32'd0);

        // Single-beat packet to tag 2.
        deliver(2, 1);
        chk("sb_done", 32'(done), 32'd1);
        chk("sb_done_tag", 32'(done_tag), 32'd2);
        chk("sb_gvld", 32'(grant_vld), 32'd0);

        // Holdoff: tree_rdy held high right after done.
        drive(1'b1, 1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("hold_ack0", 32'(ack_seen), 32'd0);
        cycle();
        chk("hold_ack1", 32'(ack_seen), 32'd0);
        cycle();
        chk("hold_ack2", 32'(ack_seen), 32'd1);
        packet(2);
        chk("hold_done_tag", 32'(done_tag), 32'd1);

        // Drop with no tag staged.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        packet(1);
        packet(0);
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("drop_dropping_b2", 32'(dropping), 32'd1);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("drop_dropping_b3", 32'(dropping), 32'd1);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("drop_cnt1", 32'(drop_cnt), 32'd2);
        chk("drop_gvld", 32'(grant_vld), 32'd0);

        // Ack/sof collision with tag 1.
        idle(ACK_HOLDOFF + 1);
        drive(1'b1, 1, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("coll_ack", 32'(ack_seen), 32'd1);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("coll_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("coll_staged", 32'(grant_tag), 32'd1);
        packet(3);
        chk("coll_done_tag", 32'(done_tag), 32'd1);
        chk("coll_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Reset on beat 2 of a packet in progress.
        idle(ACK_HOLDOFF + 1);
        drive(1'b1, 2, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cycle();
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("rstb_gvld", 32'(grant_vld), 32'd0);
        chk("rstb_done", 32'(done), 32'd0);
        chk("rstb_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rstb_drop_cnt", 32'(drop_cnt), 32'd0);

        // Saturation: 5 packets into a 2-bit counter.
        for (int p = 0; p < 5; p++) deliver(p % N, 1 + (p % 3));
        chk("sat_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_snoop_grant_ctrl
